// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set by issue, cleared by write-back, set wins on a
// same-address collision. Register 0 is never marked busy.
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a new producer outranks the retiring one.
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy1 = busy_q[ra1];
  assign busy2 = busy_q[ra2];

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with a post-reset clearing sweep and a busy
// scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              ready,
  output rf_state_e         dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sb_set, sb_clr;
  logic              sb_busy1, sb_busy2;

  logic [DATA_W-1:0] rf_q [DEPTH];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) state_d = RF_RUN;
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_CLEAR;
    endcase
  end

  // Outputs: the sweep owns the write port until RUN.
  always_comb begin
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_clr  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
      end
      RF_RUN: begin
        ready   = 1'b1;
        wr_en   = we3 && (wa3 != '0);
        wr_addr = wa3;
        wr_data = wd3;
        sb_set  = issue;
        sb_clr  = we3;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  // Storage is deliberately unreset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) rf_q[wr_addr] <= wr_data;
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (sb_set),
    .set_addr (issue_addr),
    .clr_en   (sb_clr),
    .clr_addr (wa3),
    .ra1      (ra1),
    .ra2      (ra2),
    .busy1    (sb_busy1),
    .busy2    (sb_busy2)
  );

  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (ready) begin
      if (ra1 != '0) begin
        rd1   = rf_q[ra1];
        busy1 = sb_busy1;
      end
      if (ra2 != '0) begin
        rd2   = rf_q[ra2];
        busy2 = sb_busy2;
      end
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is already produced, so busy only reflects a same-cycle issue.
      if (we3 && (wa3 == ra1) && (ra1 != '0)) begin
        rd1   = wd3;
        busy1 = issue && (issue_addr == ra1);
      end
      if (we3 && (wa3 == ra2) && (ra2 != '0)) begin
        rd2   = wd3;
        busy2 = issue && (issue_addr == ra2);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 32x32 instance checked every cycle against an
// array model, plus a directed 8x16 instance.
module tb_regfile_sb;
  import regfile_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Default-size DUT
  logic [4:0]  ra1, ra2, wa3, issue_addr;
  logic [31:0] rd1, rd2, wd3;
  logic        busy1, busy2, we3, issue, ready;
  rf_state_e   dbg_state;

  regfile_sb u_dut (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .issue(issue), .issue_addr(issue_addr), .ready(ready), .dbg_state(dbg_state)
  );

  // Small DUT
  logic [2:0]  s_ra1, s_ra2, s_wa3, s_issue_addr;
  logic [15:0] s_rd1, s_rd2, s_wd3;
  logic        s_busy1, s_busy2, s_we3, s_issue, s_ready;
  rf_state_e   s_dbg_state;

  regfile_sb #(.DATA_W(16), .ADDR_W(3)) u_small (
    .clk(clk), .reset_n(reset_n), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .busy1(s_busy1), .busy2(s_busy2), .we3(s_we3), .wa3(s_wa3), .wd3(s_wd3),
    .issue(s_issue), .issue_addr(s_issue_addr), .ready(s_ready), .dbg_state(s_dbg_state)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: after 32 clean edges everything reads zero and RUN rules apply.
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_ready;
  int          m_edges;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready = 1'b0;
      m_edges = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == 32) begin
        m_ready = 1'b1;
        foreach (m_rf[i]) m_rf[i] = '0;
      end
    end else begin
      if (we3 && wa3 != 0) begin
        m_rf[wa3]   = wd3;
        m_busy[wa3] = 1'b0;
      end
      if (issue && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (!m_ready || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == ra) return wd3;
`endif
    return m_rf[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (!m_ready || ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == ra) return issue && issue_addr == ra;
`endif
    return m_busy[ra];
  endfunction

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", 64'(ready), 64'(m_ready));
      check("cyc_rd1",   64'(rd1),   64'(exp_rd(ra1)));
      check("cyc_rd2",   64'(rd2),   64'(exp_rd(ra2)));
      check("cyc_busy1", 64'(busy1), 64'(exp_busy(ra1)));
      check("cyc_busy2", 64'(busy2), 64'(exp_busy(ra2)));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 0; issue = 0; wa3 = 0; wd3 = 0; issue_addr = 0;
    s_we3 = 0; s_issue = 0; s_wa3 = 0; s_wd3 = 0; s_issue_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int big_at, small_at;
    logic [31:0] exp_old;
    reset_n = 1'b1;
    idle();
    ra1 = 0; ra2 = 0; s_ra1 = 0; s_ra2 = 0;
    #3 reset_n = 1'b0;
    step();
    chk_en = 1'b1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rd1",   64'(rd1),   64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(RF_CLEAR));
    step();
    reset_n = 1'b1;

    // Sweep length for both sizes
    big_at = 0; small_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready && big_at == 0) big_at = i;
      if (s_ready && small_at == 0) small_at = i;
    end
    check("ready_edges_32", 64'(big_at), 64'd32);
    check("ready_edges_8",  64'(small_at), 64'd8);

    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #2 check("sweep_zero", 64'(rd1), 64'd0);
      step();
    end

    // Small-instance round trip
    s_we3 = 1; s_wa3 = 3'd6; s_wd3 = 16'hBEEF;
    step();
    s_we3 = 0; s_ra1 = 3'd6; s_ra2 = 3'd0;
    #2 check("small_rt", 64'(s_rd1), 64'hBEEF);
    check("small_r0", 64'(s_rd2), 64'd0);

    // Directed write/read
    we3 = 1; wa3 = 5; wd3 = 32'hDEADBEEF;
    step();
    we3 = 0; ra1 = 5;
    #2 check("wr5", 64'(rd1), 64'hDEADBEEF);
    we3 = 1; wa3 = 0; wd3 = 32'h1234; ra1 = 0;
    step();
    we3 = 0;
    #2 check("r0_zero", 64'(rd1), 64'd0);

    // Scoreboard
    issue = 1; issue_addr = 7;
    step();
    issue = 0; ra1 = 7;
    #2 check("busy7_set", 64'(busy1), 64'd1);
    we3 = 1; wa3 = 7; wd3 = 32'h7777;
    step();
    we3 = 0;
    #2 check("busy7_clr", 64'(busy1), 64'd0);
    issue = 1; issue_addr = 7; we3 = 1; wa3 = 7; wd3 = 32'hCAFEF00D;
    step();
    idle();
    #2 check("busy7_setwins", 64'(busy1), 64'd1);
    check("rd7_new", 64'(rd1), 64'hCAFEF00D);

    // Bypass
    we3 = 1; wa3 = 9; wd3 = 32'h11111111;
    step();
    wd3 = 32'hA5A5A5A5; ra2 = 9;
`ifdef REGFILE_BYPASS_EN
    exp_old = 32'hA5A5A5A5;
`else
    exp_old = 32'h11111111;
`endif
    #2 check("bypass_same_cycle", 64'(rd2), 64'(exp_old));
    step();
    we3 = 0;
    #2 check("rd9_next", 64'(rd2), 64'hA5A5A5A5);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step();
      we3 = ($urandom_range(0, 2) != 0);
      issue = ($urandom_range(0, 2) == 0);
      wa3 = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      issue_addr = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wd3 = $urandom;
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 31));
    end
    step();
    idle();

    // Reset mid-run
    we3 = 1; wa3 = 3; wd3 = 32'h55;
    step();
    we3 = 0; issue = 1; issue_addr = 3;
    step();
    issue = 0; ra1 = 3;
    #2 check("pre_rst_busy3", 64'(busy1), 64'd1);
    check("pre_rst_rd3", 64'(rd1), 64'h55);
    reset_n = 1'b0;
    #1 check("async_busy3", 64'(busy1), 64'd0);
    check("async_ready", 64'(ready), 64'd0);
    check("async_rd3", 64'(rd1), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) check("resweep_not_ready", 64'(ready), 64'd0);
      we3 = 1; wa3 = 3; wd3 = 32'h77;
    end
    we3 = 0;
    #2 check("resweep_ready", 64'(ready), 64'd1);
    check("resweep_rd3", 64'(rd1), 64'd0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
